// File: rtl/median_window_5x5.sv
// median_window_5x5: 5x5 pixel window for the median path, with fill tracking and aligned syncs.
// Define MEDIAN_WINDOW_ZERO_INVALID_EN to drive window/center to 0 while win_valid is low.
module median_window_5x5 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic [WIDTH-1:0]   row0,
  input  logic [WIDTH-1:0]   row1,
  input  logic [WIDTH-1:0]   row2,
  input  logic [WIDTH-1:0]   row3,
  input  logic [WIDTH-1:0]   row4,
  input  logic               de_in,
  input  logic               h_sync_in,
  input  logic               v_sync_in,
  output logic [25*WIDTH-1:0] window,
  output logic [WIDTH-1:0]   center,
  output logic               win_valid,
  output logic               de_out,
  output logic               h_sync_out,
  output logic               v_sync_out
);
  logic [WIDTH-1:0]   r_win [5][5];
  logic [2:0]         r_col_cnt;
  logic [2:0]         r_line_cnt;
  logic               r_de_prev;
  logic               r_win_valid;
  logic               r_de_out;
  logic               r_h_sync;
  logic               r_v_sync;
  logic [WIDTH-1:0]   w_row [5];
  logic               w_accept;
  logic               w_de_fall;
  logic [25*WIDTH-1:0] w_raw;

  assign w_row[0]  = row0;
  assign w_row[1]  = row1;
  assign w_row[2]  = row2;
  assign w_row[3]  = row3;
  assign w_row[4]  = row4;
  assign w_accept  = ce & de_in;
  assign w_de_fall = ce & r_de_prev & ~de_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_win       <= '{default: '0};
      r_col_cnt   <= '0;
      r_line_cnt  <= '0;
      r_de_prev   <= 1'b0;
      r_win_valid <= 1'b0;
      r_de_out    <= 1'b0;
      r_h_sync    <= 1'b0;
      r_v_sync    <= 1'b0;
    end else if (ce) begin
      if (w_accept)
        for (int r = 0; r < 5; r++) begin
          for (int c = 4; c > 0; c--) r_win[r][c] <= r_win[r][c-1];
          r_win[r][0] <= w_row[r];
        end
      r_col_cnt   <= w_de_fall ? 3'd0 : (w_accept && r_col_cnt != 3'd4) ? r_col_cnt + 3'd1 : r_col_cnt;
      // frame blanking clears the line count even when a line ends in the same cycle
      r_line_cnt  <= v_sync_in ? 3'd0 : (w_de_fall && r_line_cnt != 3'd4) ? r_line_cnt + 3'd1 : r_line_cnt;
      r_de_prev   <= de_in;
      r_win_valid <= w_accept && r_col_cnt == 3'd4 && r_line_cnt == 3'd4;
      r_de_out    <= de_in;
      r_h_sync    <= h_sync_in;
      r_v_sync    <= v_sync_in;
    end
  end

  for (genvar r = 0; r < 5; r++) begin : g_row
    for (genvar c = 0; c < 5; c++) begin : g_col
      assign w_raw[(5*r+c)*WIDTH +: WIDTH] = r_win[r][c];
    end
  end

`ifdef MEDIAN_WINDOW_ZERO_INVALID_EN
  assign window = r_win_valid ? w_raw : '0;
  assign center = r_win_valid ? r_win[2][2] : '0;
`else
  assign window = w_raw;
  assign center = r_win[2][2];
`endif
  assign win_valid  = r_win_valid;
  assign de_out     = r_de_out;
  assign h_sync_out = r_h_sync;
  assign v_sync_out = r_v_sync;
endmodule

// File: tb/tb_median_window_5x5.sv
// tb_median_window_5x5: directed stimulus, behavioural window model checked every cycle, plus literal expectations.
module tb_median_window_5x5;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b1;
  logic de_in = 1'b0;
  logic hs_in = 1'b0;
  logic vs_in = 1'b0;
  logic [W-1:0] rows [5];
  logic [25*W-1:0] window;
  logic [W-1:0] center;
  logic win_valid, de_out, hs_out, vs_out;
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  median_window_5x5 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .row0(rows[0]), .row1(rows[1]), .row2(rows[2]), .row3(rows[3]), .row4(rows[4]),
    .de_in(de_in), .h_sync_in(hs_in), .v_sync_in(vs_in),
    .window(window), .center(center), .win_valid(win_valid),
    .de_out(de_out), .h_sync_out(hs_out), .v_sync_out(vs_out)
  );

  task automatic chk(input string nm, input logic [25*W-1:0] act, input logic [25*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: window element (r,c) is the c-th most recent accepted pixel of row r;
  // a window is valid once 4 earlier pixels in this line and 4 completed lines this frame exist
  logic [W-1:0] m_hist [5][5];
  int m_pix, m_lines;
  bit m_prev, m_valid, m_de, m_hs, m_vs;
  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) m_hist[r][c] = '0;
      m_pix = 0; m_lines = 0; m_prev = 0; m_valid = 0; m_de = 0; m_hs = 0; m_vs = 0;
    end else if (ce) begin
      m_valid = de_in && m_pix >= 4 && m_lines >= 4;
      if (de_in) begin
        for (int r = 0; r < 5; r++) begin
          for (int c = 4; c > 0; c--) m_hist[r][c] = m_hist[r][c-1];
          m_hist[r][0] = rows[r];
        end
        m_pix++;
      end
      if (m_prev && !de_in) begin m_pix = 0; m_lines++; end
      if (vs_in) m_lines = 0;
      m_prev = de_in; m_de = de_in; m_hs = hs_in; m_vs = vs_in;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [25*W-1:0] ew;
      logic [W-1:0] ec;
      for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) ew[(5*r+c)*W +: W] = m_hist[r][c];
      ec = m_hist[2][2];
`ifdef MEDIAN_WINDOW_ZERO_INVALID_EN
      if (!m_valid) begin ew = '0; ec = '0; end
`endif
      chk("model_window", window, ew);
      chk("model_center", {192'b0, center}, {192'b0, ec});
      chk("model_valid", {199'b0, win_valid}, {199'b0, m_valid});
      chk("model_syncs", {197'b0, de_out, hs_out, vs_out}, {197'b0, m_de, m_hs, m_vs});
    end
  end

  int line_valid [16];
  int first_l, first_c;
  logic [W-1:0] first_center, first_w00;

  task automatic drive(input bit c_e, input bit d, input bit hs, input bit vs, input bit rs, input int l, input int col);
    ce = c_e; de_in = d; hs_in = hs; vs_in = vs; rst = rs;
    for (int r = 0; r < 5; r++) rows[r] = (d && l - r >= 0) ? W'((16 * (l - r) + col) & 8'hff) : '0;
    @(posedge clk); #1;
    if (d && win_valid && l < 16) begin
      line_valid[l]++;
      if (first_l < 0) begin first_l = l; first_c = col; first_center = center; first_w00 = window[W-1:0]; end
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 16; i++) line_valid[i] = 0;
    first_l = -1; first_c = -1;
  endtask

  // vsync pulse, then nl lines of npx pixels with 4 blanking cycles; optional vsync/reset at (ev_line, 2/3)
  task automatic frame(input int nl, input int npx, input int vs_line, input int rst_line);
    clear_stats();
    drive(1, 0, 0, 1, 0, 0, 0);
    for (int l = 0; l < nl; l++) begin
      for (int c = 0; c < npx; c++) begin
        drive(1, 1, c == 0, l == vs_line && c == 2, l == rst_line && c == 3, l, c);
        if (l == rst_line && c == 3) chk("win_after_rst", window, '0);
      end
      for (int b = 0; b < 4; b++) drive(1, 0, 0, 0, 0, l, 0);
    end
  endtask

  int total, run, maxrun;
  bit last_hs;
  initial begin
    for (int r = 0; r < 5; r++) rows[r] = '0;
    clear_stats();
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    chk("rst_window", window, '0);
    chk("rst_misc", {192'b0, center}, '0);
    chk("rst_flags", {196'b0, win_valid, de_out, hs_out, vs_out}, '0);
    rst = 0; ce = 0; de_in = 1; rows[0] = 8'hAA; hs_in = 1; vs_in = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_window", window, '0);
    chk("idle_flags", {196'b0, win_valid, de_out, hs_out, vs_out}, '0);

    frame(8, 8, -1, -1);
    chk("fill_first_line", first_l, 4);
    chk("fill_first_col", first_c, 4);
    chk("fill_first_center", {192'b0, first_center}, 8'h22);
    chk("fill_first_w00", {192'b0, first_w00}, 8'h44);
    total = 0;
    for (int i = 0; i < 16; i++) total += line_valid[i];
    chk("fill_valid_count", total, 16);

    run = 0; maxrun = 0; total = 0;
    for (int c = 0; c < 10; c++) begin
      drive(1, 1, 0, 0, 0, 9, c);
      if (win_valid) begin total++; run++; if (run > maxrun) maxrun = run; end else run = 0;
    end
    chk("line10_valid_count", total, 6);
    chk("line10_run", maxrun, 6);
    drive(1, 0, 0, 0, 0, 9, 0);
    chk("line10_fall_valid", {199'b0, win_valid}, 0);
    for (int b = 0; b < 3; b++) drive(1, 0, 0, 0, 0, 9, 0);
    clear_stats();
    for (int c = 0; c < 8; c++) drive(1, 1, 0, 0, 0, 10, c);
    chk("col_restart_first", first_c, 4);
    chk("col_restart_count", line_valid[10], 4);
    for (int b = 0; b < 4; b++) drive(1, 0, 0, 0, 0, 10, 0);

    begin
      logic [11:0] hp, vp;
      hp = 12'b1011_0011_1010; vp = 12'b0011_1001_0011;
      for (int i = 0; i < 12; i++) begin
        drive(1, 0, hp[i], vp[i], 0, 0, 0);
        chk("sync_h", {199'b0, hs_out}, {199'b0, hp[i]});
        chk("sync_v", {199'b0, vs_out}, {199'b0, vp[i]});
      end
      last_hs = hp[11];
      for (int i = 0; i < 12; i++) begin
        drive(i % 2 == 0, 0, ~hp[i], 0, 0, 0, 0);
        if (i % 2 == 0) last_hs = ~hp[i];
        chk("sync_ce_gate", {199'b0, hs_out}, {199'b0, last_hs});
      end
    end

    frame(11, 8, 6, -1);
    total = 0;
    for (int i = 6; i < 10; i++) total += line_valid[i];
    chk("vs_mid_invalid", total, 0);
    chk("vs_mid_recover", line_valid[10], 4);

    frame(10, 8, -1, 5);
    total = 0;
    for (int i = 5; i < 9; i++) total += line_valid[i];
    chk("rst_mid_invalid", total, 0);
    chk("rst_mid_recover", line_valid[9], 4);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/median_window_5x5.md
Name: median_window_5x5

Overview:
- Downstream consumer of the four chained BRAM line delays in the 5x5 median path.
- Takes the live pixel plus the four line-delayed taps (one tap per image row) and shifts them into a 5x5 register window.
- Tracks column and line fill, so the median sorter only sees windows built entirely from valid pixels.
- Forwards the sync/enable signals aligned to the window.

Parameters:
- WIDTH, 8, pixel width in bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- ce  in  1  clock enable; state advances only when ce=1.
- row0  in  WIDTH  current pixel (newest line).
- row1  in  WIDTH  line-delay tap, 1 line old.
- row2  in  WIDTH  line-delay tap, 2 lines old.
- row3  in  WIDTH  line-delay tap, 3 lines old.
- row4  in  WIDTH  line-delay tap, 4 lines old.
- de_in  in  1  data enable accompanying row0..row4.
- h_sync_in  in  1  horizontal sync.
- v_sync_in  in  1  vertical sync; high = frame blanking.
- window  out  25*WIDTH  packed window; element (r,c) at bits [(5*r+c)*WIDTH +: WIDTH]. r=0 is the newest line, c=0 the newest column.
- center  out  WIDTH  element (2,2).
- win_valid  out  1  window fully populated with current-frame pixels.
- de_out  out  1  de_in delayed to match window.
- h_sync_out  out  1  h_sync_in delayed to match window.
- v_sync_out  out  1  v_sync_in delayed to match window.

Behaviour:
- Priority: rst has priority over ce; when rst=1 every register clears at the clock edge, independent of ce. When ce=0, nothing changes and all outputs hold.
- Reset values: all 25 window registers = 0, center = 0, win_valid = 0, de_out = 0, h_sync_out = 0, v_sync_out = 0, col_cnt = 0, line_cnt = 0, de_prev = 0.
- Accept condition: accept = ce & de_in.
- Window shift on accept, every r in 0..4:
  - w[r][c] <= w[r][c-1] for c = 4..1;
  - w[r][0] <= row_r.
- When ce=1 and de_in=0, the window holds.
- col_cnt (3 bits): counts accepted pixels in the current line and saturates at 4. It clears on a de falling edge (ce & de_prev & ~de_in).
- line_cnt (3 bits): counts completed lines and saturates at 4.
  - Increments on a de falling edge.
  - Clears whenever ce & v_sync_in. If both happen in the same cycle, the clear wins.
- de_prev: updates to de_in on every ce cycle.
- win_valid, registered: win_valid <= accept & (col_cnt==4) & (line_cnt==4), using pre-update counter values.
  - The 5th and later pixels of the 5th and later lines of a frame produce valid windows.
  - win_valid is 0 on any ce cycle without accept.
- Latency: 1 ce-cycle from inputs to window, center, win_valid, de_out, h_sync_out and v_sync_out. The sync outputs are a plain 1-stage ce-gated register.
- Interaction with line delays: this block assumes row1..row4 already carry the line-aligned taps. It adds no line latency of its own.
- Right/bottom image borders: no padding. The output image loses 4 columns and 4 rows; downstream keys on win_valid.
- Reset mid-line: counters restart at 0, so the remainder of the current frame stays invalid until line_cnt reaches 4 again after the next line completions.
- v_sync asserted mid-line: line_cnt clears at once and col_cnt is unaffected until the next de fall.

Optional Feature:
- Macro: MEDIAN_WINDOW_ZERO_INVALID_EN.
- Defined: window and center are driven as 0 whenever win_valid=0, via output gating on the registered valid. This gives a clean debug/ILA view.
- Undefined: window and center always show raw register contents, including stale and partial data. Timing and win_valid are identical in both builds.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with ce=1 -> all outputs 0, win_valid=0. Then ce=0 with de_in=1 and row0=0xAA -> outputs unchanged.
- Fill sequence, frame of 8x8 with pixel = 16*line + col on row0 and taps equal to the same pattern from earlier lines; v_sync pulse first, de 8 high / 4 low per line:
  - first win_valid=1 at line 4, col 4, with center = 0x22 and window(0,0) = 0x44;
  - exactly 16 valid windows per frame.
- Column saturation and line end: 10-pixel line -> win_valid high for 6 consecutive cycles. It drops the cycle after de_in falls, and col_cnt = 0 after the fall.
- Sync alignment: h_sync_in and v_sync_in toggled at arbitrary cycles with ce=1 -> outputs reproduce the pattern exactly 1 cycle later. With ce alternating 1/0, the delay counts ce cycles only.
- Mid-frame v_sync and rst: v_sync_in=1 during line 6 -> win_valid=0 until 4 more lines complete. rst pulse at pixel 3 of line 5 -> same recovery, and window registers read 0 right after reset.
- Feature build with MEDIAN_WINDOW_ZERO_INVALID_EN: repeat the fill test -> window = 0 and center = 0 on every cycle where win_valid=0. Valid-cycle data is identical to the non-feature build.
